piso_sched: RTL and testbench

//  Word scheduler and sequencer for the 10-bit piso serializer.
//  - Arbitrates round-robin between two word sources using valid/ready handshakes.
//  - Drives the piso load pulse and parallel word every WIDTH cycles, so the serial

---
 rtl/piso_sched.sv | 135 +++++++++++++
 tb/tb_piso_sched.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/piso_sched.sv
// piso_sched
// Word scheduler for a 10-bit piso serializer. Picks words round-robin from two
// valid/ready sources. Issues a one-cycle load with the parallel word every
// WIDTH cycles so the serial stream has no gaps. Loads IDLE_WORD when neither
// source has data.
//
// Ports
//   clk           system clock, rising edge
//   reset_L       asynchronous active-low reset
//   enable        run the stream; when low, the stream stops at the next word boundary
//   req0_*        source 0 valid/data/ready
//   req1_*        source 1 valid/data/ready
//   load          registered one-cycle load pulse to the piso
//   parallel_out  word for the piso; held until the next load
//   bit_idx       index of the bit being shifted, 0..WIDTH-1
//   grant         source of the current word: 01=src0, 10=src1, 00=idle fill
//   busy          a word is being serialized
//   idle_ins      pulse aligned with load when IDLE_WORD is loaded
//
// state  | meaning
// IDLE   | stream stopped, waiting for enable
// SHIFT  | a word is being serialized, bit_idx counts its bits
module piso_sched #(
    parameter int              WIDTH     = 10,
    parameter logic [WIDTH-1:0] IDLE_WORD = 10'b0011111010,
    parameter int              CNT_W     = 4
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             enable,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             load,
    output logic [WIDTH-1:0] parallel_out,
    output logic [CNT_W-1:0] bit_idx,
    output logic [1:0]       grant,
    output logic             busy,
    output logic             idle_ins
);

    typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           r_state,    w_state_nxt;
    logic [CNT_W-1:0] r_bit_idx,  w_bit_idx_nxt;
    logic             r_load,     w_load_nxt;
    logic [WIDTH-1:0] r_par,      w_par_nxt;
    logic [1:0]       r_grant,    w_grant_nxt;
    logic             r_idle_ins, w_idle_ins_nxt;
    // 0 = src0 was granted last, 1 = src1 was granted last
    logic             r_last_grant, w_last_grant_nxt;

    logic w_last_bit;
    logic w_bnd;
    logic w_pick0;
    logic w_pick1;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_state      <= ST_IDLE;
            r_bit_idx    <= '0;
            r_load       <= 1'b0;
            r_par        <= '0;
            r_grant      <= 2'b00;
            r_idle_ins   <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_bit_idx    <= w_bit_idx_nxt;
            r_load       <= w_load_nxt;
            r_par        <= w_par_nxt;
            r_grant      <= w_grant_nxt;
            r_idle_ins   <= w_idle_ins_nxt;
            r_last_grant <= w_last_grant_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_bit_idx_nxt    = r_bit_idx;
        w_load_nxt       = 1'b0;
        w_par_nxt        = r_par;
        w_grant_nxt      = r_grant;
        w_idle_ins_nxt   = 1'b0;
        w_last_grant_nxt = r_last_grant;

        w_last_bit = (r_state == ST_SHIFT) && (r_bit_idx == LAST_BIT);
        // reset_L gates the boundary so no ready escapes while reset is held
        w_bnd   = reset_L && enable && ((r_state == ST_IDLE) || w_last_bit);
        // with both sources valid, the one not granted last wins
        w_pick0 = req0_valid && (!req1_valid || r_last_grant);
        w_pick1 = req1_valid && (!req0_valid || !r_last_grant);

        if (w_bnd) begin
            w_state_nxt    = ST_SHIFT;
            w_bit_idx_nxt  = '0;
            w_load_nxt     = 1'b1;
            w_grant_nxt    = {w_pick1, w_pick0};
            w_idle_ins_nxt = !w_pick0 && !w_pick1;
            if (w_pick0) begin
                w_par_nxt        = req0_data;
                w_last_grant_nxt = 1'b0;
            end else if (w_pick1) begin
                w_par_nxt        = req1_data;
                w_last_grant_nxt = 1'b1;
            end else begin
                w_par_nxt = IDLE_WORD;
            end
        end else if (r_state == ST_SHIFT) begin
            if (w_last_bit) begin
                // word finished with enable low: stop, keep parallel_out
                w_state_nxt   = ST_IDLE;
                w_bit_idx_nxt = '0;
                w_grant_nxt   = 2'b00;
            end else begin
                w_bit_idx_nxt = r_bit_idx + 1'b1;
            end
        end
    end

    assign req0_ready   = w_bnd && w_pick0;
    assign req1_ready   = w_bnd && w_pick1;
    assign load         = r_load;
    assign parallel_out = r_par;
    assign bit_idx      = r_bit_idx;
    assign grant        = r_grant;
    assign busy         = (r_state == ST_SHIFT);
    assign idle_ins     = r_idle_ins;

endmodule

// File: tb/tb_piso_sched.sv
module tb_piso_sched;

    localparam int W = 10;
    localparam logic [W-1:0] IDLE_W = 10'b0011111010;

    logic         clk = 1'b0;
    logic         reset_L = 1'b0;
    logic         enable = 1'b0;
    logic         req0_valid = 1'b0;
    logic [W-1:0] req0_data = '0;
    logic         req0_ready;
    logic         req1_valid = 1'b0;
    logic [W-1:0] req1_data = '0;
    logic         req1_ready;
    logic         load;
    logic [W-1:0] parallel_out;
    logic [3:0]   bit_idx;
    logic [1:0]   grant;
    logic         busy;
    logic         idle_ins;

    piso_sched #(.WIDTH(W), .IDLE_WORD(IDLE_W), .CNT_W(4)) dut (
        .clk          (clk),
        .reset_L      (reset_L),
        .enable       (enable),
        .req0_valid   (req0_valid),
        .req0_data    (req0_data),
        .req0_ready   (req0_ready),
        .req1_valid   (req1_valid),
        .req1_data    (req1_data),
        .req1_ready   (req1_ready),
        .load         (load),
        .parallel_out (parallel_out),
        .bit_idx      (bit_idx),
        .grant        (grant),
        .busy         (busy),
        .idle_ins     (idle_ins)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: a word in flight is described by how many cycles of it
    // have elapsed; the arbiter remembers who won last (0/1).
    bit           m_running;
    int           m_elapsed;
    int           m_last;
    logic [W-1:0] m_word;
    int           m_src;      // 0, 1, or 2 for idle fill
    bit           m_fresh;    // word was loaded on the last edge
    int           loads_seen;

    task automatic model_reset();
        m_running = 0;
        m_elapsed = 0;
        m_last    = 1;
        m_word    = '0;
        m_src     = 2;
        m_fresh   = 0;
    endtask

    function automatic logic [1:0] grant_code(input int src);
        return (src == 0) ? 2'b01 : (src == 1) ? 2'b10 : 2'b00;
    endfunction

    task automatic cycle(input bit en, input bit v0, input logic [W-1:0] d0,
                         input bit v1, input logic [W-1:0] d1);
        bit boundary;
        int pick;
        @(negedge clk);
        enable = en; req0_valid = v0; req0_data = d0; req1_valid = v1; req1_data = d1;
        #1;
        boundary = en && (!m_running || m_elapsed == W - 1);
        pick = -1;
        if (boundary) begin
            if (v0 && v1)  pick = 1 - m_last;
            else if (v0)   pick = 0;
            else if (v1)   pick = 1;
            else           pick = 2;
        end
        check("req0_ready", 32'(req0_ready), 32'(pick == 0));
        check("req1_ready", 32'(req1_ready), 32'(pick == 1));
        @(posedge clk);
        #1;
        m_fresh = 0;
        if (boundary) begin
            m_running = 1;
            m_elapsed = 0;
            m_fresh   = 1;
            m_src     = pick;
            m_word    = (pick == 0) ? d0 : (pick == 1) ? d1 : IDLE_W;
            if (pick < 2) m_last = pick;
        end else if (m_running) begin
            if (m_elapsed == W - 1) begin
                m_running = 0;
                m_elapsed = 0;
            end else begin
                m_elapsed++;
            end
        end
        if (load === 1'b1) loads_seen++;
        check("load",         32'(load),         32'(m_fresh));
        check("idle_ins",     32'(idle_ins),     32'(m_fresh && m_src == 2));
        check("parallel_out", 32'(parallel_out), 32'(m_word));
        check("grant",        32'(grant),        32'(m_running ? grant_code(m_src) : 2'b00));
        check("busy",         32'(busy),         32'(m_running));
        check("bit_idx",      32'(bit_idx),      32'(m_elapsed));
    endtask

    task automatic do_reset();
        #2;
        enable = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
        reset_L = 1'b0;
        #1;
        check("rst_load",   32'(load),         32'd0);
        check("rst_par",    32'(parallel_out), 32'd0);
        check("rst_ready0", 32'(req0_ready),   32'd0);
        check("rst_ready1", 32'(req1_ready),   32'd0);
        check("rst_busy",   32'(busy),         32'd0);
        check("rst_grant",  32'(grant),        32'd0);
        check("rst_bit",    32'(bit_idx),      32'd0);
        model_reset();
        @(negedge clk);
        enable = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        reset_L = 1'b1;
    endtask

    initial begin
        model_reset();
        loads_seen = 0;
        do_reset();

        // single word, then idle fill
        cycle(1, 1, 10'b0101010101, 0, '0);
        for (int i = 0; i < 12; i++) cycle(1, 0, '0, 0, '0);

        // contention: alternating grants
        do_reset();
        for (int i = 0; i < 45; i++) cycle(1, 1, 10'b1100110011, 1, 10'b1111111111);

        // idle fill from a stopped stream: 5 loads in 50 cycles
        do_reset();
        loads_seen = 0;
        for (int i = 0; i < 50; i++) cycle(1, 0, '0, 0, '0);
        check("t4_load_count", 32'(loads_seen), 32'd5);

        // stop mid-word at bit 4
        begin
            int guard = 0;
            while (!(m_running && m_elapsed == 4) && guard < 30) begin
                cycle(1, 0, '0, 0, '0);
                guard++;
            end
            check("t5_reached_bit4", 32'(m_running && m_elapsed == 4), 32'd1);
        end
        loads_seen = 0;
        for (int i = 0; i < 15; i++) cycle(0, 1, 10'h155, 0, '0);
        check("t5_no_load", 32'(loads_seen), 32'd0);

        // reset at bit 6, then both valid: src0 must win first
        cycle(1, 0, '0, 0, '0);
        begin
            int guard = 0;
            while (!(m_running && m_elapsed == 6) && guard < 30) begin
                cycle(1, 0, '0, 0, '0);
                guard++;
            end
            check("t6_reached_bit6", 32'(m_running && m_elapsed == 6), 32'd1);
        end
        do_reset();
        cycle(1, 1, 10'h2AA, 1, 10'h0F0);
        check("t6_first_grant", 32'(grant), 32'(2'b01));
        for (int i = 0; i < 12; i++) cycle(1, 1, 10'h2AA, 1, 10'h0F0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 15) != 0),
                  1'($urandom_range(0, 1)), W'($urandom_range(0, 1023)),
                  1'($urandom_range(0, 1)), W'($urandom_range(0, 1023)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
